// File: rtl/ahb_sched_pkg.sv
`default_nettype none
// ============================================================================
// ahb_sched_pkg : shared AHB encodings, FSM state codes and defaults
// Rev 1.0
// ============================================================================
package ahb_sched_pkg;

   typedef enum logic [1:0] {
      TRANS_IDLE   = 2'b00,
      TRANS_BUSY   = 2'b01,
      TRANS_NONSEQ = 2'b10,
      TRANS_SEQ    = 2'b11
   } trans_e;

   typedef enum logic [1:0] {
      SIZE_BYTE    = 2'b00,
      SIZE_HALF    = 2'b01,
      SIZE_WORD    = 2'b10,
      SIZE_ILLEGAL = 2'b11
   } size_e;

   typedef enum logic {
      RESP_OKAY  = 1'b0,
      RESP_ERROR = 1'b1
   } resp_e;

   localparam logic [2:0] BURST_SINGLE = 3'b000;

   typedef logic [1:0] state_e;
   localparam state_e S_IDLE = 2'd0;
   localparam state_e S_ADDR = 2'd1;
   localparam state_e S_DATA = 2'd2;
   localparam state_e S_ERR  = 2'd3;

   localparam logic [31:0] IDLE_ADDR_DEFAULT = 32'hF000_0000;

   function automatic logic size_is_legal(input logic [1:0] size);
      return size != SIZE_ILLEGAL;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_bus_sched_if.sv
`default_nettype none
// ============================================================================
// ahb_bus_sched_if : requester handshake plus AHB master-side signals
// Rev 1.0
// ============================================================================
interface ahb_bus_sched_if;
   logic [1:0]        req_valid;
   logic [1:0]        req_write;
   logic [1:0][1:0]   req_size;
   logic [1:0][31:0]  req_addr;
   logic [1:0][31:0]  req_wdata;
   logic [1:0]        req_done;
   logic [1:0]        req_err;
   logic [31:0]       req_rdata;
   logic              busy;
   logic [31:0]       PADDR;
   logic              PWRITE;
   logic [1:0]        PSIZE;
   logic [1:0]        PTRANS;
   logic [2:0]        PBURST;
   logic [31:0]       PWDATA;
   logic [31:0]       PRDATA;
   logic              PREADY;
   logic              PRESP;

   modport master (
      input  req_valid, req_write, req_size, req_addr, req_wdata,
      input  PRDATA, PREADY, PRESP,
      output req_done, req_err, req_rdata, busy,
      output PADDR, PWRITE, PSIZE, PTRANS, PBURST, PWDATA
   );

   modport slave (
      output req_valid, req_write, req_size, req_addr, req_wdata,
      output PRDATA, PREADY, PRESP,
      input  req_done, req_err, req_rdata, busy,
      input  PADDR, PWRITE, PSIZE, PTRANS, PBURST, PWDATA
   );
endinterface
`default_nettype wire

// File: rtl/ahb_rr_arb2.sv
`default_nettype none
// ============================================================================
// ahb_rr_arb2 : two-way round-robin arbiter, combinational grant
// Rev 1.0
// ============================================================================
module ahb_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant,
   output logic       last_grant
);

   logic last_grant_q, last_grant_d;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
      last_grant_d = last_grant_q;
      if (advance && (grant != 2'b00)) begin
         last_grant_d = grant[1];
      end
   end

   // Reset to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

   assign last_grant = last_grant_q;

endmodule
`default_nettype wire

// File: rtl/ahb_bus_sched.sv
`default_nettype none
// ============================================================================
// ahb_bus_sched : two-requester AHB data-port scheduler with busy/done handshake
// Optional macro AHB_TIMEOUT_EN bounds wait states to TIMEOUT_CYCLES.   Rev 1.0
// ============================================================================
module ahb_bus_sched
   import ahb_sched_pkg::*;
#(
   parameter logic [31:0] IDLE_ADDR      = IDLE_ADDR_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic            clk,
   input  logic            rst,
   ahb_bus_sched_if.master bus
);

   state_e       state_q, state_d;
   logic         owner_q, owner_d;
   logic         write_q, write_d;
   logic [1:0]   size_q, size_d;
   logic [31:0]  addr_q, addr_d;
   logic [31:0]  wdata_q, wdata_d;
   logic [1:0]   ptrans_q, ptrans_d;
   logic [31:0]  paddr_q, paddr_d;
   logic         pwrite_q, pwrite_d;
   logic [1:0]   psize_q, psize_d;
   logic [31:0]  pwdata_q, pwdata_d;
   logic [1:0]   done_q, done_d;
   logic [1:0]   err_q, err_d;
   logic [31:0]  rdata_q, rdata_d;
   logic         busy_q, busy_d;

   logic [1:0]   req_eff;
   logic [1:0]   grant;
   logic         advance;
   logic         sel;
   logic         resp_err;
   logic         timeout;
   logic         unused_last_grant;

   // A requester is not re-arbitrated in the cycle its done is visible.
   assign req_eff  = bus.req_valid & ~done_q;
   assign sel      = grant[1];
   assign resp_err = (bus.PRESP == RESP_ERROR);

   ahb_rr_arb2 u_arb (
      .clk        (clk),
      .rst        (rst),
      .req        (req_eff),
      .advance    (advance),
      .grant      (grant),
      .last_grant (unused_last_grant)
   );

`ifdef AHB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

   assign timeout = (state_q != S_IDLE) && !bus.PREADY &&
                    (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if ((state_d != state_q) || (state_q == S_IDLE)) begin
         wait_cnt_d = '0;
      end else if (!bus.PREADY) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end
`else
   assign timeout = 1'b0;
   if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
   end
`endif

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      write_d  = write_q;
      size_d   = size_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      ptrans_d = TRANS_IDLE;
      paddr_d  = IDLE_ADDR;
      pwrite_d = pwrite_q;
      psize_d  = psize_q;
      pwdata_d = pwdata_q;
      done_d   = 2'b00;
      err_d    = 2'b00;
      rdata_d  = rdata_q;
      advance  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (grant != 2'b00) begin
               advance = 1'b1;
               owner_d = sel;
               write_d = bus.req_write[sel];
               size_d  = bus.req_size[sel];
               addr_d  = bus.req_addr[sel];
               wdata_d = bus.req_wdata[sel];
               if (!size_is_legal(bus.req_size[sel])) begin
                  done_d[sel] = 1'b1;
                  err_d[sel]  = 1'b1;
                  rdata_d     = '0;
               end else begin
                  state_d  = S_ADDR;
                  ptrans_d = TRANS_NONSEQ;
                  paddr_d  = bus.req_addr[sel];
                  pwrite_d = bus.req_write[sel];
                  psize_d  = bus.req_size[sel];
               end
            end
         end
         S_ADDR: begin
            if (bus.PREADY) begin
               state_d  = S_DATA;
               pwdata_d = write_q ? wdata_q : '0;
            end else begin
               ptrans_d = TRANS_NONSEQ;
               paddr_d  = addr_q;
               pwrite_d = write_q;
               psize_d  = size_q;
            end
         end
         S_DATA: begin
            if (bus.PREADY) begin
               // READY together with ERROR is still reported as an error.
               state_d         = S_IDLE;
               done_d[owner_q] = 1'b1;
               err_d[owner_q]  = resp_err;
               rdata_d         = (resp_err || write_q) ? '0 : bus.PRDATA;
               pwdata_d        = '0;
            end else if (resp_err) begin
               state_d = S_ERR;
            end
         end
         S_ERR: begin
            if (bus.PREADY) begin
               state_d         = S_IDLE;
               done_d[owner_q] = 1'b1;
               err_d[owner_q]  = 1'b1;
               rdata_d         = '0;
               pwdata_d        = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (timeout) begin
         state_d         = S_IDLE;
         ptrans_d        = TRANS_IDLE;
         paddr_d         = IDLE_ADDR;
         done_d          = 2'b00;
         err_d           = 2'b00;
         done_d[owner_q] = 1'b1;
         err_d[owner_q]  = 1'b1;
         rdata_d         = '0;
         pwdata_d        = '0;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         owner_q  <= 1'b0;
         write_q  <= 1'b0;
         size_q   <= SIZE_WORD;
         addr_q   <= '0;
         wdata_q  <= '0;
         ptrans_q <= TRANS_IDLE;
         paddr_q  <= IDLE_ADDR;
         pwrite_q <= 1'b0;
         psize_q  <= SIZE_WORD;
         pwdata_q <= '0;
         done_q   <= 2'b00;
         err_q    <= 2'b00;
         rdata_q  <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         write_q  <= write_d;
         size_q   <= size_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         ptrans_q <= ptrans_d;
         paddr_q  <= paddr_d;
         pwrite_q <= pwrite_d;
         psize_q  <= psize_d;
         pwdata_q <= pwdata_d;
         done_q   <= done_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.PTRANS    = ptrans_q;
   assign bus.PADDR     = paddr_q;
   assign bus.PWRITE    = pwrite_q;
   assign bus.PSIZE     = psize_q;
   assign bus.PBURST    = BURST_SINGLE;
   assign bus.PWDATA    = pwdata_q;
   assign bus.req_done  = done_q;
   assign bus.req_err   = err_q;
   assign bus.req_rdata = rdata_q;
   assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_bus_sched.sv
`default_nettype none
// ============================================================================
// tb_ahb_bus_sched : scoreboard bench for the two-requester AHB scheduler
// Rev 1.0
// ============================================================================
module tb_ahb_bus_sched;
   import ahb_sched_pkg::*;

   typedef struct {
      logic [1:0]  done;
      logic [1:0]  err;
      logic [31:0] rdata;
   } exp_t;

   localparam logic [108:0] RST_VALS = {2'b00, 32'hF000_0000, 1'b0, 2'b10, 3'b000,
                                        32'h0, 2'b00, 2'b00, 32'h0, 1'b0};

   logic clk = 1'b0;
   logic rst;
   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic lg      = 1'b1;

   always #5 clk = ~clk;

   ahb_bus_sched_if bus ();

   ahb_bus_sched #(
      .IDLE_ADDR      (32'hF000_0000),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   function automatic logic [108:0] out_vec();
      return {bus.PTRANS, bus.PADDR, bus.PWRITE, bus.PSIZE, bus.PBURST, bus.PWDATA,
              bus.req_done, bus.req_err, bus.req_rdata, bus.busy};
   endfunction

   task automatic drive_req(input int id, input logic wr, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd);
      bus.req_write[id] = wr;
      bus.req_size[id]  = sz;
      bus.req_addr[id]  = a;
      bus.req_wdata[id] = wd;
      bus.req_valid[id] = 1'b1;
   endtask

   task automatic wait_done(input int max_cyc, output bit got, output int cyc, output int nn);
      got = 1'b0; cyc = 0; nn = 0;
      while (!got && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
         if (bus.PTRANS == 2'b10) nn++;
         if (bus.req_done != 2'b00) got = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if (out_vec() !== RST_VALS) begin
         n_fail++;
         $display("FAIL reset_values: got %h required %h", out_vec(), RST_VALS);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_read();
      bit got; int cyc, nn; exp_t e;
      bus.PRDATA = 32'hDEAD_BEEF;
      bus.PREADY = 1'b1;
      drive_req(0, 1'b0, 2'b10, 32'h0001_0004, 32'h0);
      sb.push_back('{2'b01, 2'b00, 32'hDEAD_BEEF});
      lg = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({bus.PTRANS, bus.PADDR, bus.PWRITE, bus.PSIZE, bus.busy} !== {2'b10, 32'h0001_0004, 1'b0, 2'b10, 1'b1}) begin
         n_fail++;
         $display("FAIL read_addr_phase: trans=%b addr=%h wr=%b size=%b busy=%b", bus.PTRANS, bus.PADDR, bus.PWRITE, bus.PSIZE, bus.busy);
      end
      wait_done(10, got, cyc, nn);
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL read_done: no req_done within 10 cycles");
      end else begin
         e = sb.pop_front();
         if (bus.req_done !== e.done || bus.req_err !== e.err || bus.req_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL read_result: done=%b err=%b rdata=%h required done=%b err=%b rdata=%h",
                     bus.req_done, bus.req_err, bus.req_rdata, e.done, e.err, e.rdata);
         end
      end
      n_tests++;
      if (cyc + 1 != 3 || nn != 0) begin
         n_fail++;
         $display("FAIL read_latency: latency=%0d extra_nonseq=%0d required 3 and 0", cyc + 1, nn);
      end
      bus.req_valid = 2'b00;
      @(negedge clk);
      n_tests++;
      if ({bus.PTRANS, bus.req_done, bus.busy} !== {2'b00, 2'b00, 1'b0}) begin
         n_fail++;
         $display("FAIL read_after: trans=%b done=%b busy=%b required 00 00 0", bus.PTRANS, bus.req_done, bus.busy);
      end
   endtask

   task automatic test_back_to_back();
      bit got; int cyc, nn, extra; exp_t e; logic w;
      bus.PRDATA = 32'hA5A5_5A5A;
      bus.PREADY = 1'b1;
      drive_req(0, 1'b0, 2'b10, 32'h0002_0000, 32'h0);
      drive_req(1, 1'b1, 2'b10, 32'h0000_1000, 32'hCAFE_0001);
      for (int k = 0; k < 4; k++) begin
         w  = lg ? 1'b0 : 1'b1;
         lg = w;
         sb.push_back('{w ? 2'b10 : 2'b01, 2'b00, w ? 32'h0 : 32'hA5A5_5A5A});
      end
      for (int k = 0; k < 4; k++) begin
         wait_done(12, got, cyc, nn);
         if (k == 3) bus.req_valid = 2'b00;
         n_tests++;
         if (!got) begin
            n_fail++;
            $display("FAIL b2b_done%0d: no req_done within 12 cycles", k);
         end else begin
            e = sb.pop_front();
            if (bus.req_done !== e.done || bus.req_err !== e.err || bus.req_rdata !== e.rdata || cyc != 3) begin
               n_fail++;
               $display("FAIL b2b_result%0d: done=%b err=%b rdata=%h gap=%0d required done=%b err=%b rdata=%h gap=3",
                        k, bus.req_done, bus.req_err, bus.req_rdata, cyc, e.done, e.err, e.rdata);
            end
         end
      end
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.req_done != 2'b00 || bus.busy) extra++;
      end
      n_tests++;
      if (extra != 0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_quiet: spurious_cycles=%0d pending=%0d required 0 and 0", extra, sb.size());
      end
   endtask

   task automatic test_write_wait();
      bit got; int cyc, nn; exp_t e;
      bus.PREADY = 1'b1;
      drive_req(1, 1'b1, 2'b10, 32'h0000_4000, 32'h1234_5678);
      sb.push_back('{2'b10, 2'b00, 32'h0});
      lg = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({bus.PTRANS, bus.PADDR, bus.PWRITE} !== {2'b10, 32'h0000_4000, 1'b1}) begin
         n_fail++;
         $display("FAIL write_addr_phase: trans=%b addr=%h wr=%b", bus.PTRANS, bus.PADDR, bus.PWRITE);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_tests++;
         if ({bus.PWDATA, bus.busy, bus.req_done} !== {32'h1234_5678, 1'b1, 2'b00}) begin
            n_fail++;
            $display("FAIL write_wait%0d: pwdata=%h busy=%b done=%b required 12345678 1 00", i, bus.PWDATA, bus.busy, bus.req_done);
         end
         bus.PREADY = (i == 3);
      end
      wait_done(5, got, cyc, nn);
      n_tests++;
      if (!got || cyc != 1) begin
         n_fail++;
         $display("FAIL write_done: got=%0d cycles=%0d required 1 and 1", got, cyc);
      end else begin
         e = sb.pop_front();
         if (bus.req_done !== e.done || bus.req_err !== e.err || bus.req_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL write_result: done=%b err=%b rdata=%h required done=%b err=%b rdata=%h",
                     bus.req_done, bus.req_err, bus.req_rdata, e.done, e.err, e.rdata);
         end
      end
      bus.req_valid = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_error();
      bit got; int cyc, nn; exp_t e;
      bus.PRDATA = 32'h1111_2222;
      bus.PREADY = 1'b1;
      bus.PRESP  = 1'b0;
      // Two-cycle ERROR response.
      drive_req(0, 1'b0, 2'b10, 32'h0003_0000, 32'h0);
      sb.push_back('{2'b01, 2'b01, 32'h0});
      lg = 1'b0;
      repeat (2) @(negedge clk);
      bus.PREADY = 1'b0; bus.PRESP = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({bus.busy, bus.req_done} !== {1'b1, 2'b00}) begin
         n_fail++;
         $display("FAIL err_first_cycle: busy=%b done=%b required 1 00", bus.busy, bus.req_done);
      end
      bus.PREADY = 1'b1;
      wait_done(5, got, cyc, nn);
      n_tests++;
      if (!got || cyc != 1) begin
         n_fail++;
         $display("FAIL err_done: got=%0d cycles=%0d required 1 and 1", got, cyc);
      end else begin
         e = sb.pop_front();
         if (bus.req_done !== e.done || bus.req_err !== e.err || bus.req_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL err_result: done=%b err=%b rdata=%h required done=%b err=%b rdata=%h",
                     bus.req_done, bus.req_err, bus.req_rdata, e.done, e.err, e.rdata);
         end
      end
      bus.req_valid = 2'b00; bus.PRESP = 1'b0;
      @(negedge clk);
      // Normal transfer right after an error.
      drive_req(1, 1'b0, 2'b01, 32'h0000_2000, 32'h0);
      sb.push_back('{2'b10, 2'b00, 32'h1111_2222});
      lg = 1'b1;
      wait_done(10, got, cyc, nn);
      n_tests++;
      if (!got || cyc != 3) begin
         n_fail++;
         $display("FAIL err_recover_done: got=%0d cycles=%0d required 1 and 3", got, cyc);
      end else begin
         e = sb.pop_front();
         if (bus.req_done !== e.done || bus.req_err !== e.err || bus.req_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL err_recover_result: done=%b err=%b rdata=%h required done=%b err=%b rdata=%h",
                     bus.req_done, bus.req_err, bus.req_rdata, e.done, e.err, e.rdata);
         end
      end
      bus.req_valid = 2'b00;
      @(negedge clk);
      // READY and ERROR together in the data phase.
      drive_req(0, 1'b0, 2'b00, 32'h0003_0001, 32'h0);
      sb.push_back('{2'b01, 2'b01, 32'h0});
      lg = 1'b0;
      repeat (2) @(negedge clk);
      bus.PRESP = 1'b1;
      wait_done(5, got, cyc, nn);
      n_tests++;
      if (!got || cyc != 1) begin
         n_fail++;
         $display("FAIL err_ready_done: got=%0d cycles=%0d required 1 and 1", got, cyc);
      end else begin
         e = sb.pop_front();
         if (bus.req_done !== e.done || bus.req_err !== e.err || bus.req_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL err_ready_result: done=%b err=%b rdata=%h required done=%b err=%b rdata=%h",
                     bus.req_done, bus.req_err, bus.req_rdata, e.done, e.err, e.rdata);
         end
      end
      bus.req_valid = 2'b00; bus.PRESP = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_illegal_size();
      bit got; int cyc, nn, bad; exp_t e;
      drive_req(1, 1'b0, 2'b11, 32'h0000_3000, 32'h0);
      sb.push_back('{2'b10, 2'b10, 32'h0});
      lg = 1'b1;
      wait_done(5, got, cyc, nn);
      n_tests++;
      if (!got || cyc != 1 || nn != 0) begin
         n_fail++;
         $display("FAIL illegal_done: got=%0d cycles=%0d nonseq=%0d required 1 1 0", got, cyc, nn);
      end else begin
         e = sb.pop_front();
         if (bus.req_done !== e.done || bus.req_err !== e.err || bus.req_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL illegal_result: done=%b err=%b rdata=%h required done=%b err=%b rdata=%h",
                     bus.req_done, bus.req_err, bus.req_rdata, e.done, e.err, e.rdata);
         end
      end
      bus.req_valid = 2'b00;
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.PTRANS != 2'b00 || bus.req_done != 2'b00 || bus.busy) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL illegal_quiet: active_cycles=%0d required 0", bad);
      end
   endtask

`ifdef AHB_TIMEOUT_EN
   task automatic test_timeout();
      bit got; int cyc, nn; exp_t e;
      bus.PREADY = 1'b0;
      drive_req(1, 1'b0, 2'b10, 32'h0000_5000, 32'h0);
      sb.push_back('{2'b10, 2'b10, 32'h0});
      lg = 1'b1;
      wait_done(30, got, cyc, nn);
      n_tests++;
      if (!got || cyc != 17 || nn != 16 || bus.PTRANS !== 2'b00) begin
         n_fail++;
         $display("FAIL timeout_done: got=%0d cycles=%0d nonseq=%0d trans=%b required 1 17 16 00", got, cyc, nn, bus.PTRANS);
      end else begin
         e = sb.pop_front();
         if (bus.req_done !== e.done || bus.req_err !== e.err || bus.req_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL timeout_result: done=%b err=%b required done=%b err=%b", bus.req_done, bus.req_err, e.done, e.err);
         end
      end
      bus.req_valid = 2'b00; bus.PREADY = 1'b1;
      @(negedge clk);
   endtask
`endif

   task automatic test_reset_mid();
      int bad;
      bus.PREADY = 1'b1;
      drive_req(0, 1'b1, 2'b10, 32'h0000_6000, 32'h5555_AAAA);
      repeat (2) @(negedge clk);
      bus.PREADY = 1'b0;
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      n_tests++;
      if (out_vec() !== RST_VALS) begin
         n_fail++;
         $display("FAIL reset_mid: got %h required %h", out_vec(), RST_VALS);
      end
      lg = 1'b1;
      @(negedge clk);
      bus.req_valid = 2'b00;
      bus.PREADY    = 1'b1;
      rst           = 1'b1;
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.req_done != 2'b00 || bus.busy || bus.PTRANS != 2'b00) bad++;
      end
      n_tests++;
      if (bad != 0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL reset_mid_quiet: active_cycles=%0d pending=%0d required 0 and 0", bad, sb.size());
      end
   endtask

   initial begin
      bus.req_valid = 2'b00;
      bus.req_write = 2'b00;
      bus.req_size  = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.PRDATA    = 32'h0;
      bus.PREADY    = 1'b1;
      bus.PRESP     = 1'b0;
      test_reset();
      test_single_read();
      test_back_to_back();
      test_write_wait();
      test_error();
      test_illegal_size();
`ifdef AHB_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
